// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared integer-pipe widths and the writeback request type
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_skid_slot.sv
// rtl/wb_skid_slot.sv - one-entry holding register for a writeback source
// A load on the same edge as a drain keeps the slot full with the new entry.
module wb_skid_slot #(
  parameter type req_t = cpu_pkg::wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic drain_i,
  input  req_t req_i,
  output logic full_o,
  output req_t req_o
);

  logic full_q, full_d;
  req_t req_q, req_d;

  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (load_i) begin
      full_d = 1'b1;
      req_d  = req_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign req_o  = req_q;

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU (A) and load/mul-div (B) results onto the regfile write port
// Fixed priority to A, oldest-first on a shared rd, and a starvation guard for B.
module writeback_arbiter #(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int REG_ADDR_W   = cpu_pkg::REG_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_idle
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } req_t;

  req_t a_q, b_q;
  logic a_full, b_full;
  logic grant_a, grant_b;
  logic a_load, b_load;
  logic a_full_nx, b_full_nx;
  logic age_q, age_d;  // 1: B holds the older entry
  logic [CW-1:0] starve_q, starve_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  wb_skid_slot #(.req_t(req_t)) u_slot_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (a_load),
    .drain_i (grant_a),
    .req_i   ('{rd: a_rd, data: a_data}),
    .full_o  (a_full),
    .req_o   (a_q)
  );

  wb_skid_slot #(.req_t(req_t)) u_slot_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (b_load),
    .drain_i (grant_b),
    .req_i   ('{rd: b_rd, data: b_data}),
    .full_o  (b_full),
    .req_o   (b_q)
  );

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      if (a_q.rd == b_q.rd) grant_b = age_q;
      else                  grant_b = (starve_q == LIMIT);
      grant_a = !grant_b;
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  assign a_ready = !rst && (!a_full || grant_a);
  assign b_ready = !rst && (!b_full || grant_b);

  // rd 0 is handshaken but never stored, so x0 is never written
  assign a_load = a_valid && a_ready && (a_rd != '0);
  assign b_load = b_valid && b_ready && (b_rd != '0);

  always_comb begin
    a_full_nx = a_load || (a_full && !grant_a);
    b_full_nx = b_load || (b_full && !grant_b);

    // A freshly loaded entry is always the younger one; a same-edge tie makes B older
    age_d = 1'b0;
    if (a_full_nx && b_full_nx) begin
      if (a_load)      age_d = 1'b1;
      else if (b_load) age_d = 1'b0;
      else             age_d = age_q;
    end

    starve_d = '0;
    if (b_full && !grant_b)
      starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CW'(1);

    wb_we_d   = grant_a || grant_b;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (grant_b) begin
      wb_rd_d   = b_q.rd;
      wb_data_d = b_q.data;
    end else if (grant_a) begin
      wb_rd_d   = a_q.rd;
      wb_data_d = a_q.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q     <= 1'b0;
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      age_q     <= age_d;
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign wb_idle = !a_full && !b_full && !wb_we_q;

endmodule
